// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: drives the PC into a combinational instruction ROM,
// tags each returned word with its PC and buffers the pair for decode.
// Latency: one registered stage (ROM word fetched in cycle N is on out_* in N+1).
// Backpressure: decode stalls via out_ready; when the buffer is full with no pop the PC holds.
//
// Ports:
//   clk, rst (async active-high)          - clock / reset
//   instr_addr, instr                     - ROM address out, combinational ROM word in
//   redirect_valid, redirect_pc           - taken branch/jump: flush buffer, reload PC
//   out_valid/out_ready/out_pc/out_instr/out_pc_plus4 - head entry to decode
//   fifo_count                            - occupied buffer entries
//   fetch_misaligned                      - only with FETCH_MISALIGN_CHECK_EN defined:
//                                           set by a redirect to a non-word-aligned target
module fetch_unit #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
    parameter int                         FIFO_DEPTH    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [ADDRESS_WIDTH-1:0]          instr_addr,
    input  logic [DATA_WIDTH-1:0]             instr,
    input  logic                              redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]          redirect_pc,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDRESS_WIDTH-1:0]          out_pc,
    output logic [DATA_WIDTH-1:0]             out_instr,
    output logic [ADDRESS_WIDTH-1:0]          out_pc_plus4,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                              fetch_misaligned
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    instr_mem_q [FIFO_DEPTH];
    logic                     push;
    logic                     pop;
    logic                     fetch_block;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    assign fetch_block      = misaligned_q;
    assign fetch_misaligned = misaligned_q;
`else
    assign fetch_block = 1'b0;
`endif

    assign instr_addr   = pc_q;
    assign out_valid    = (count_q != '0);
    assign out_pc       = pc_mem_q[rd_ptr_q];
    assign out_instr    = instr_mem_q[rd_ptr_q];
    assign out_pc_plus4 = out_pc + ADDRESS_WIDTH'(4);
    assign fifo_count   = count_q;

    always_comb begin
        pop  = out_valid & out_ready;
        // A full buffer can still accept a word when the head leaves this cycle.
        push = !redirect_valid & !fetch_block & ((count_q < DEPTH_C) | pop);

        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif

        if (redirect_valid) begin
            // Redirect wins over everything; a pop this cycle is simply discarded by the flush.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_d         = redirect_pc;
            misaligned_d = (redirect_pc[1:0] != 2'b00);
`else
            pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
`endif
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + ADDRESS_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    // Storage is cleared on reset so the head outputs read zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= pc_q;
            instr_mem_q[wr_ptr_q] <= instr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic [1:0]  fifo_count;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM[i] = 0x1000 + i, indexed by the word address.
    assign instr = 32'h0000_1000 + {2'b00, instr_addr[31:2]};

    fetch_unit #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'h0000_0000),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_addr     (instr_addr),
        .instr          (instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_pc_plus4   (out_pc_plus4),
        .fifo_count     (fifo_count)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_valid",  32'(out_valid),  32'h0);
        chk("rst_pc",     out_pc,          32'h0);
        chk("rst_instr",  out_instr,       32'h0);
        chk("rst_plus4",  out_pc_plus4,    32'h4);
        chk("rst_count",  32'(fifo_count), 32'h0);
        chk("rst_addr",   instr_addr,      32'h0);

        // Streaming with out_ready=1: one word per cycle from the cycle after release
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("str_valid", 32'(out_valid),  32'h1);
            chk("str_pc",    out_pc,          32'(4 * (k - 1)));
            chk("str_instr", out_instr,       32'h1000 + 32'(k - 1));
            chk("str_plus4", out_pc_plus4,    32'(4 * k));
            chk("str_count", 32'(fifo_count), 32'h1);
        end

        // Backpressure: out_ready low for 5 cycles after release
        rst = 1'b1;
        #2;
        rst = 1'b0;
        out_ready = 1'b0;
        step();
        chk("bp_count1", 32'(fifo_count), 32'h1);
        step();
        chk("bp_count2", 32'(fifo_count), 32'h2);
        chk("bp_addr2",  instr_addr,      32'h8);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_count", 32'(fifo_count), 32'h2);
            chk("bp_hold_addr",  instr_addr,      32'h8);
            chk("bp_hold_pc",    out_pc,          32'h0);
            chk("bp_hold_instr", out_instr,       32'h1000);
        end
        out_ready = 1'b1;
        step();
        chk("bp_drain_pc4",  out_pc,          32'h4);
        chk("bp_drain_ins",  out_instr,       32'h1001);
        chk("bp_drain_cnt",  32'(fifo_count), 32'h2);
        step();
        chk("bp_drain_pc8",  out_pc,          32'h8);
        chk("bp_drain_ins8", out_instr,       32'h1002);
        step();
        chk("bp_drain_pc12", out_pc,          32'hC);

        // Redirect to 0x40 while full
        out_ready = 1'b0;
        step();
        chk("rd_full_count", 32'(fifo_count), 32'h2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid0", 32'(out_valid),  32'h0);
        chk("rd_count0", 32'(fifo_count), 32'h0);
        chk("rd_addr",   instr_addr,      32'h40);
        out_ready = 1'b1;
        step();
        chk("rd_valid1", 32'(out_valid), 32'h1);
        chk("rd_pc",     out_pc,         32'h40);
        chk("rd_instr",  out_instr,      32'h1010);

        // Redirect with simultaneous pop, then back-to-back redirect to 0x80
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        chk("b2b_valid0", 32'(out_valid), 32'h0);
        chk("b2b_addr0",  instr_addr,     32'h40);
        redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        chk("b2b_valid1", 32'(out_valid), 32'h0);
        chk("b2b_addr1",  instr_addr,     32'h80);
        step();
        chk("b2b_pc0",    out_pc,    32'h80);
        chk("b2b_instr0", out_instr, 32'h1020);
        step();
        chk("b2b_pc1",    out_pc,    32'h84);
        chk("b2b_instr1", out_instr, 32'h1021);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid),  32'h0);
        chk("arst_addr",  instr_addr,      32'h0);
        chk("arst_count", 32'(fifo_count), 32'h0);
        rst = 1'b0;
        step();
        chk("arst_pc0",  out_pc,    32'h0);
        chk("arst_ins0", out_instr, 32'h1000);
        step();
        chk("arst_pc1",  out_pc,    32'h4);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr",  instr_addr,     32'hFFFF_FFFC);
        chk("wrap_valid", 32'(out_valid), 32'h0);
        step();
        chk("wrap_pc0",    out_pc,       32'hFFFF_FFFC);
        chk("wrap_plus4",  out_pc_plus4, 32'h0);
        chk("wrap_instr0", out_instr,    32'h4000_0FFF);
        step();
        chk("wrap_pc1",    out_pc,       32'h0);
        chk("wrap_instr1", out_instr,    32'h1000);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect blocks fetch until an aligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        chk("mis_flag",  32'(fetch_misaligned), 32'h1);
        chk("mis_addr",  instr_addr,            32'h42);
        chk("mis_valid", 32'(out_valid),        32'h0);
        step();
        step();
        chk("mis_hold_flag",  32'(fetch_misaligned), 32'h1);
        chk("mis_hold_valid", 32'(out_valid),        32'h0);
        chk("mis_hold_count", 32'(fifo_count),       32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h44;
        step();
        redirect_valid = 1'b0;
        chk("mis_clr_flag", 32'(fetch_misaligned), 32'h0);
        chk("mis_clr_addr", instr_addr,            32'h44);
        step();
        chk("mis_clr_pc",    out_pc,    32'h44);
        chk("mis_clr_instr", out_instr, 32'h1011);
`else
        // Misaligned target fetches the containing word
        redirect_valid = 1'b1;
        redirect_pc    = 32'h46;
        step();
        redirect_valid = 1'b0;
        chk("mis_addr", instr_addr, 32'h44);
        step();
        chk("mis_pc",    out_pc,    32'h44);
        chk("mis_instr", out_instr, 32'h1011);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the RV32 pipeline front end; drives the word address into the combinational instruction ROM in the fetch stage and captures the returned word each cycle.
- Holds the fetch PC and tags each fetched word with its PC.
- Buffers fetched pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles taken-branch/jump redirects by flushing the buffer and reloading the PC.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instr_addr
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
FIFO_DEPTH, 2, fetch buffer entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
instr_addr  output  ADDRESS_WIDTH  byte address to instruction memory; memory indexes instr_addr[31:2]
instr  input  DATA_WIDTH  instruction word, combinational response to instr_addr in the same cycle
redirect_valid  input  1  taken branch/jump from execute
redirect_pc  input  ADDRESS_WIDTH  redirect target
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode accepts head entry
out_pc  output  ADDRESS_WIDTH  PC of head entry
out_instr  output  DATA_WIDTH  instruction of head entry
out_pc_plus4  output  ADDRESS_WIDTH  out_pc + 4, modulo 2^ADDRESS_WIDTH
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC, count=0, rd/wr pointers=0, all FIFO storage=0; hence out_valid=0, out_pc=0, out_instr=0, out_pc_plus4=4, fifo_count=0, instr_addr=RESET_PC. Reset mid-operation discards all buffered entries.
- instr_addr = pc_q combinationally, with no registering.
- pop = out_valid & out_ready.
- push = !redirect_valid & ((count < FIFO_DEPTH) | pop).
- On push: write {pc_q, instr} at the write pointer; pc_q <= pc_q + 4, wrapping from 32'hFFFF_FFFC to 0.
- With no push and no redirect, pc_q holds. Full with no pop is a stall: pc_q holds and instr_addr is stable.
- out_valid = (count != 0). out_pc/out_instr come from the head entry. Head data stays stable while out_valid & !out_ready.
- Push and pop in the same cycle: count is unchanged and legal at any occupancy, including full.
- Latency: word at address A is fetched in cycle N and is on out_* in cycle N+1 at the earliest (one registered stage).
- Redirect has highest priority. In the cycle redirect_valid=1:
  - no push;
  - at the edge: count<=0, pointers<=0, pc_q<=redirect_pc with bits [1:0] forced to 00.
  - Cycle N+1: out_valid=0 and instr_addr=target.
  - Cycle N+2: first target instruction on out_*, provided no further redirect.
- A pop handshake in the redirect cycle still counts as a transfer; squashing it is downstream hazard logic's job.
- Back-to-back redirects: the last one wins. Each redirect flushes again.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=00 loads pc_q=redirect_pc unmodified and sets fetch_misaligned=1 from the next cycle.
  - While set, push is forced to 0 and the FIFO stays empty.
  - It clears only on a later redirect with aligned target, or on reset.
- Undefined: the port is absent, low bits are forced to 00, and misaligned targets fetch the containing word.

Test Plan:
- Reset release, out_ready=1, ROM[i]=0x1000+i -> from the cycle after release, out_valid=1 every cycle; out_pc=0,4,8,... paired with out_instr=0x1000,0x1001,...; out_pc_plus4=out_pc+4.
- out_ready=0 for 5 cycles after release -> fifo_count reaches 2 and holds; instr_addr holds 8; out_pc=0 stable. Raise out_ready -> 0,4,8 delivered with no loss or duplication.
- Redirect to 0x40 while full (count=2) -> next cycle out_valid=0, fifo_count=0, instr_addr=0x40; following cycle out_pc=0x40, out_instr=ROM[16].
- Redirect with simultaneous pop, then a second redirect to 0x80 the next cycle -> only 0x80-path entries appear afterwards; 0x40 is never presented.
- rst asserted asynchronously mid-stream (between edges) -> out_valid drops immediately, instr_addr=RESET_PC; after release the sequence restarts at RESET_PC.
- PC wrap: redirect to 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0000_0000, with out_pc_plus4=0x0 on the first. With FETCH_MISALIGN_CHECK_EN: redirect to 0x42 -> fetch_misaligned=1, out_valid stays 0; redirect to 0x44 clears it.
